// File: rtl/mmio_spi.sv
// mmio_spi: memory-mapped SPI master (mode 0, MSB first) for the 0x10024000 page.
// One request decoded per cycle, registered one-cycle response, TX/RX byte FIFOs.
// Build option: MMIO_SPI_LOOPBACK_EN routes spi_mosi into the receive shifter
// instead of spi_miso.
//
// state | meaning
// IDLE  | waiting for a TX byte; CS released unless HOLD keeps it low
// LEAD  | CS asserted, bit 7 on MOSI, one half-period before first SCK rise
// SHIFT | 16 half-periods, SCK toggles at each terminal count
// TRAIL | one half-period after last fall, then next byte or IDLE
module mmio_spi #(
    parameter int DIV_W   = 12,
    parameter int FIFO_LG = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rq_en,
    input  logic [31:0] rq_addr,
    input  logic        rq_iswrite,
    input  logic [31:0] rq_data,
    output logic        rq_hit,
    output logic        rs_en,
    output logic [31:0] rs_data,
    output logic        spi_clk,
    output logic        spi_cs,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam int DEPTH = 1 << FIFO_LG;
    localparam logic [1:0] CS_HOLD = 2'd2;
    localparam logic [1:0] CS_OFF  = 2'd3;
    localparam logic [FIFO_LG:0] PTR_ONE = 1;
    localparam logic [DIV_W-1:0] CNT_ONE = 1;

    typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;

    state_t state, state_nx;

    logic [DIV_W-1:0] sckdiv, cnt;
    logic [1:0]       csmode;
    logic [11:0]      off;
    logic             acc, wr_div, wr_csm, wr_tx, rd_rx;
    logic [31:0]      rd_data;

    logic [7:0]       tx_mem [DEPTH];
    logic [7:0]       rx_mem [DEPTH];
    logic [FIFO_LG:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic             tx_empty, tx_full, rx_empty, rx_full;
    logic             tx_push, tx_pop, rx_push, rx_pop;
    logic [7:0]       tx_rd, rx_rd;

    logic [7:0]       tx_sh, rx_sh;
    logic [2:0]       bit_cnt;
    logic             tc, cnt_load, sck_rise, sck_fall, frame_done, rx_in;

`ifdef MMIO_SPI_LOOPBACK_EN
    logic unused_bits;
    assign unused_bits = ^{rq_data[31:DIV_W], spi_miso};
    assign rx_in = spi_mosi;
`else
    logic unused_bits;
    assign unused_bits = ^rq_data[31:DIV_W];
    assign rx_in = spi_miso;
`endif

    assign rq_hit = (rq_addr[31:12] == 20'h10024);
    assign acc    = rq_en & rq_hit;
    assign off    = rq_addr[11:0];
    assign wr_div = acc &  rq_iswrite & (off == 12'h000);
    assign wr_csm = acc &  rq_iswrite & (off == 12'h018);
    assign wr_tx  = acc &  rq_iswrite & (off == 12'h048);
    assign rd_rx  = acc & ~rq_iswrite & (off == 12'h04c);

    assign tx_empty = (tx_wp == tx_rp);
    assign tx_full  = (tx_wp[FIFO_LG] != tx_rp[FIFO_LG]) &&
                      (tx_wp[FIFO_LG-1:0] == tx_rp[FIFO_LG-1:0]);
    assign rx_empty = (rx_wp == rx_rp);
    assign rx_full  = (rx_wp[FIFO_LG] != rx_rp[FIFO_LG]) &&
                      (rx_wp[FIFO_LG-1:0] == rx_rp[FIFO_LG-1:0]);
    assign tx_rd    = tx_mem[tx_rp[FIFO_LG-1:0]];
    assign rx_rd    = rx_mem[rx_rp[FIFO_LG-1:0]];

    assign tx_push = wr_tx & ~tx_full;
    assign rx_pop  = rd_rx & ~rx_empty;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    assign rx_push = frame_done & (~rx_full | rx_pop);
    assign tc      = (cnt == '0);

    // read data mux; FIFO status is taken from the request cycle
    always_comb begin
        rd_data = '0;
        if (!rq_iswrite) begin
            case (off)
                12'h000: rd_data = 32'(sckdiv);
                12'h018: rd_data = {30'b0, csmode};
                12'h048: rd_data = {tx_full, 31'b0};
                12'h04c: rd_data = rx_empty ? 32'h8000_0000 : {24'b0, rx_rd};
                default: rd_data = '0;
            endcase
        end
    end

    // registered one-cycle response and configuration registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rs_en   <= 1'b0;
            rs_data <= '0;
            sckdiv  <= DIV_W'(3);
            csmode  <= 2'd0;
        end else begin
            rs_en   <= acc;
            rs_data <= acc ? rd_data : '0;
            if (wr_div) sckdiv <= rq_data[DIV_W-1:0];
            if (wr_csm) csmode <= rq_data[1:0];
        end
    end

    // FIFO pointers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_wp <= '0;
            tx_rp <= '0;
            rx_wp <= '0;
            rx_rp <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + PTR_ONE;
            if (tx_pop)  tx_rp <= tx_rp + PTR_ONE;
            if (rx_push) rx_wp <= rx_wp + PTR_ONE;
            if (rx_pop)  rx_rp <= rx_rp + PTR_ONE;
        end
    end

    // FIFO storage, no reset needed behind the pointers
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp[FIFO_LG-1:0]] <= rq_data[7:0];
        if (rx_push) rx_mem[rx_wp[FIFO_LG-1:0]] <= rx_sh;
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // FSM next state and per-cycle strobes
    always_comb begin
        state_nx   = state;
        tx_pop     = 1'b0;
        cnt_load   = 1'b0;
        sck_rise   = 1'b0;
        sck_fall   = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (!tx_empty) begin
                    tx_pop   = 1'b1;
                    cnt_load = 1'b1;
                    state_nx = LEAD;
                end
            end
            LEAD: begin
                if (tc) begin
                    cnt_load = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (tc) begin
                    cnt_load = 1'b1;
                    if (!spi_clk) begin
                        sck_rise = 1'b1;
                    end else begin
                        sck_fall = 1'b1;
                        if (bit_cnt == 3'd7) begin
                            frame_done = 1'b1;
                            state_nx   = TRAIL;
                        end
                    end
                end
            end
            TRAIL: begin
                if (tc) begin
                    if (!tx_empty) begin
                        tx_pop   = 1'b1;
                        cnt_load = 1'b1;
                        state_nx = LEAD;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // half-period timer, shifters, SCK/MOSI/CS outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            spi_clk  <= 1'b0;
            spi_cs   <= 1'b1;
            spi_mosi <= 1'b0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            bit_cnt  <= '0;
        end else begin
            if (cnt_load)  cnt <= sckdiv;
            else if (!tc)  cnt <= cnt - CNT_ONE;

            if (sck_rise) begin
                spi_clk <= 1'b1;
                rx_sh   <= {rx_sh[6:0], rx_in};
            end
            if (sck_fall) begin
                spi_clk <= 1'b0;
                bit_cnt <= bit_cnt + 3'd1;
                if (!frame_done) begin
                    tx_sh    <= {tx_sh[6:0], 1'b0};
                    spi_mosi <= tx_sh[6];
                end
            end
            if (tx_pop) begin
                tx_sh    <= tx_rd;
                spi_mosi <= tx_rd[7];
                bit_cnt  <= '0;
            end

            // HOLD keeps CS low across IDLE; a mode change only lands in IDLE
            if (state == IDLE) begin
                if (tx_pop)                spi_cs <= (csmode == CS_OFF);
                else if (csmode != CS_HOLD) spi_cs <= 1'b1;
            end else if (state_nx == IDLE && csmode != CS_HOLD) begin
                spi_cs <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mmio_spi.sv
// tb_mmio_spi: table-driven register checks plus directed SPI frame sequences.
module tb_mmio_spi;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rq_en, rq_iswrite;
    logic [31:0] rq_addr, rq_data;
    logic        rq_hit, rs_en;
    logic [31:0] rs_data;
    logic        spi_clk, spi_cs, spi_mosi, spi_miso;

    logic        miso_sel = 1'b1;
    logic [7:0]  slv_byte = 8'h3C;
    logic [7:0]  slv_sh = 8'h3C;
    logic [7:0]  mon_bits = 8'h00;
    int          sck_rises = 0;
    int          cs_low_cycles = 0;
    int          cs_rises = 0;
    int          total = 0;
    int          bad = 0;

    localparam logic [31:0] A_DIV = 32'h1002_4000;
    localparam logic [31:0] A_CSM = 32'h1002_4018;
    localparam logic [31:0] A_TX  = 32'h1002_4048;
    localparam logic [31:0] A_RX  = 32'h1002_404c;

    mmio_spi dut (
        .clk        (clk),
        .reset      (reset),
        .rq_en      (rq_en),
        .rq_addr    (rq_addr),
        .rq_iswrite (rq_iswrite),
        .rq_data    (rq_data),
        .rq_hit     (rq_hit),
        .rs_en      (rs_en),
        .rs_data    (rs_data),
        .spi_clk    (spi_clk),
        .spi_cs     (spi_cs),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso)
    );

    always #5 clk = ~clk;

    // external loopback or a mode-0 slave rotating a fixed byte
    assign spi_miso = miso_sel ? spi_mosi : slv_sh[7];

    always @(negedge spi_clk or posedge reset) begin
        if (reset) slv_sh <= slv_byte;
        else       slv_sh <= {slv_sh[6:0], slv_sh[7]};
    end

    always @(posedge spi_clk) begin
        mon_bits  <= {mon_bits[6:0], spi_mosi};
        sck_rises <= sck_rises + 1;
    end

    always @(negedge clk) if (spi_cs === 1'b0) cs_low_cycles <= cs_low_cycles + 1;
    always @(posedge spi_cs) cs_rises <= cs_rises + 1;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
        logic        hit;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic req(input logic [31:0] a, input logic w, input logic [31:0] d,
                       output logic hit, output logic en1, output logic [31:0] r,
                       output logic en2);
        @(negedge clk);
        rq_en = 1'b1; rq_addr = a; rq_iswrite = w; rq_data = d;
        #1 hit = rq_hit;
        @(negedge clk);
        rq_en = 1'b0;
        en1 = rs_en; r = rs_data;
        @(negedge clk);
        en2 = rs_en;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic h, e1, e2;
        logic [31:0] r;
        req(a, 1'b1, d, h, e1, r, e2);
    endtask

    task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
        logic h, e1, e2;
        logic [31:0] r;
        req(a, 1'b0, 32'h0, h, e1, r, e2);
        chk(nm, r, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_sck, s_low, s_rise;
        logic h, e1, e2;
        logic [31:0] r;

        rq_en = 1'b0; rq_addr = '0; rq_iswrite = 1'b0; rq_data = '0;

        tbl[0]  = '{A_TX,            1'b0, 32'h0,         1'b1, 32'h0000_0000};
        tbl[1]  = '{A_RX,            1'b0, 32'h0,         1'b1, 32'h8000_0000};
        tbl[2]  = '{A_DIV,           1'b0, 32'h0,         1'b1, 32'h0000_0003};
        tbl[3]  = '{A_CSM,           1'b0, 32'h0,         1'b1, 32'h0000_0000};
        tbl[4]  = '{A_DIV,           1'b1, 32'hABCD_E123, 1'b1, 32'h0000_0000};
        tbl[5]  = '{A_DIV,           1'b0, 32'h0,         1'b1, 32'h0000_0123};
        tbl[6]  = '{A_CSM,           1'b1, 32'h0000_0003, 1'b1, 32'h0000_0000};
        tbl[7]  = '{A_CSM,           1'b0, 32'h0,         1'b1, 32'h0000_0003};
        tbl[8]  = '{32'h1002_4010,   1'b1, 32'h0000_FFFF, 1'b1, 32'h0000_0000};
        tbl[9]  = '{32'h1002_4010,   1'b0, 32'h0,         1'b1, 32'h0000_0000};
        tbl[10] = '{32'h1002_5048,   1'b0, 32'h0,         1'b0, 32'h0000_0000};
        tbl[11] = '{A_DIV,           1'b1, 32'h0000_0000, 1'b1, 32'h0000_0000};
        tbl[12] = '{A_CSM,           1'b1, 32'h0000_0000, 1'b1, 32'h0000_0000};
        tbl[13] = '{A_DIV,           1'b0, 32'h0,         1'b1, 32'h0000_0000};

        repeat (3) @(negedge clk);
        chk("rst_cs", {31'b0, spi_cs}, 32'd1);
        chk("rst_sck", {31'b0, spi_clk}, 32'd0);
        chk("rst_mosi", {31'b0, spi_mosi}, 32'd0);
        chk("rst_rs_en", {31'b0, rs_en}, 32'd0);
        chk("rst_rs_data", rs_data, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            req(tbl[i].addr, tbl[i].wr, tbl[i].data, h, e1, r, e2);
            chk($sformatf("v%0d_hit", i), {31'b0, h}, {31'b0, tbl[i].hit});
            chk($sformatf("v%0d_rs_en", i), {31'b0, e1}, {31'b0, tbl[i].hit});
            if (tbl[i].hit) chk($sformatf("v%0d_data", i), r, tbl[i].exp);
            chk($sformatf("v%0d_rs_once", i), {31'b0, e2}, 32'd0);
        end

        // single byte, sckdiv=0, AUTO, external loopback
        s_sck = sck_rises; s_low = cs_low_cycles;
        wr(A_TX, 32'h0000_00A5);
        repeat (40) @(negedge clk);
        chk("a_cs_low", cs_low_cycles - s_low, 32'd18);
        chk("a_sck", sck_rises - s_sck, 32'd8);
        chk("a_mosi", {24'b0, mon_bits}, 32'h0000_00A5);
        rd_chk("a_rx", A_RX, 32'h0000_00A5);
        rd_chk("a_rx_empty", A_RX, 32'h8000_0000);

        // HOLD keeps CS low until csmode leaves HOLD
        wr(A_CSM, 32'd2);
        wr(A_TX, 32'h0000_0081);
        repeat (40) @(negedge clk);
        chk("e_hold_cs", {31'b0, spi_cs}, 32'd0);
        wr(A_CSM, 32'd0);
        repeat (2) @(negedge clk);
        chk("e_release_cs", {31'b0, spi_cs}, 32'd1);
        rd_chk("e_rx", A_RX, 32'h0000_0081);

        // TX full drop, back-to-back frames with continuous CS, RX overrun
        wr(A_DIV, 32'd3);
        s_sck = sck_rises; s_low = cs_low_cycles; s_rise = cs_rises;
        for (int i = 1; i <= 9; i++) wr(A_TX, i);
        rd_chk("b_tx_full", A_TX, 32'h8000_0000);
        wr(A_TX, 32'h0000_000A);
        repeat (800) @(negedge clk);
        chk("b_sck", sck_rises - s_sck, 32'd72);
        chk("b_cs_low", cs_low_cycles - s_low, 32'd648);
        chk("b_cs_rises", cs_rises - s_rise, 32'd1);
        rd_chk("b_tx_drained", A_TX, 32'h0000_0000);
        for (int i = 1; i <= 8; i++) rd_chk($sformatf("b_rx%0d", i), A_RX, i);
        rd_chk("b_rx_lost", A_RX, 32'h8000_0000);

        // reset in the middle of SHIFT, then a normal frame from the slave model
        miso_sel = 1'b0;
        wr(A_TX, 32'h0000_00FF);
        repeat (8) @(negedge clk);
        chk("c_in_shift", {30'b0, spi_clk, spi_mosi}, 32'd3);
        #2 reset = 1'b1;
        #1;
        chk("c_rst_cs", {31'b0, spi_cs}, 32'd1);
        chk("c_rst_sck", {31'b0, spi_clk}, 32'd0);
        chk("c_rst_mosi", {31'b0, spi_mosi}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        rd_chk("c_rx_empty", A_RX, 32'h8000_0000);
        rd_chk("c_div_rst", A_DIV, 32'd3);
        wr(A_TX, 32'h0000_005A);
        repeat (100) @(negedge clk);
        chk("c_mosi", {24'b0, mon_bits}, 32'h0000_005A);
        rd_chk("c_rx_miso", A_RX, 32'h0000_003C);

        // OFF mode: CS never asserted, frame still runs
        miso_sel = 1'b1;
        wr(A_CSM, 32'd3);
        s_sck = sck_rises; s_low = cs_low_cycles;
        wr(A_TX, 32'h0000_00FF);
        repeat (100) @(negedge clk);
        chk("d_cs_low", cs_low_cycles - s_low, 32'd0);
        chk("d_sck", sck_rises - s_sck, 32'd8);
        chk("d_mosi", {24'b0, mon_bits}, 32'h0000_00FF);
        rd_chk("d_rx", A_RX, 32'h0000_00FF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
